// File: rtl/gemm_result_writer.sv
// GeMM result writer: buffers result tiles in a small FIFO
// and commits them to the output SRAM at consecutive addresses.
module gemm_result_writer #(
  parameter int AddrWidth = 16,
  parameter int DataWidth = 128,
  parameter int M         = 4,
  parameter int N         = 4,
  parameter int FifoDepth = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] M_size_i,
  input  logic [AddrWidth-1:0] N_size_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic                 result_valid_i,
  input  logic [DataWidth-1:0] result_data_i,
  output logic                 sram_req_o,
  input  logic                 sram_gnt_i,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o
);

  localparam int MSh = $clog2(M);
  localparam int NSh = $clog2(N);
  localparam int PW  = $clog2(FifoDepth);
  localparam logic [PW:0] Depth = (PW+1)'(FifoDepth);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [AddrWidth-1:0] r_total;
  logic [AddrWidth-1:0] r_base;
  logic [AddrWidth-1:0] r_accepted;
  logic [AddrWidth-1:0] r_written;
  logic                 r_error;

  logic [DataWidth-1:0] r_mem [FifoDepth];
  logic [PW-1:0]        r_wptr;
  logic [PW-1:0]        r_rptr;
  logic [PW:0]          r_count;

  logic [AddrWidth-1:0] w_msz;
  logic [AddrWidth-1:0] w_nsz;
  logic [AddrWidth-1:0] w_total;
  logic                 w_run;
  logic                 w_start;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic                 w_last;

  assign w_msz   = M_size_i >> MSh;
  assign w_nsz   = N_size_i >> NSh;
  assign w_total = w_msz * w_nsz;

  assign w_run   = (r_state == S_RUN);
  assign w_start = (r_state == S_IDLE) && start_i;
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == Depth);

  // The head is never bypassed: a pop needs an entry already stored.
  assign w_pop  = w_run && !w_empty && sram_gnt_i;
  assign w_push = w_run && result_valid_i
               && (r_accepted < r_total)
               && (!w_full || w_pop);
  assign w_drop = w_run && result_valid_i && !w_push;
  assign w_last = w_pop
               && ((r_written + AddrWidth'(1)) == r_total);

  assign sram_req_o   = w_run && !w_empty;
  assign sram_we_o    = sram_req_o;
  assign sram_addr_o  = w_run ? (r_base + r_written) : '0;
  assign sram_wdata_o = w_run ? r_mem[r_rptr] : '0;

  assign busy_o  = (r_state == S_RUN) || (r_state == S_DONE);
  assign done_o  = (r_state == S_DONE);
  assign error_o = r_error;

  // Control FSM, tile counters and sticky drop flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_total    <= '0;
      r_base     <= '0;
      r_accepted <= '0;
      r_written  <= '0;
      r_error    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_total    <= w_total;
            r_base     <= base_addr_i;
            r_accepted <= '0;
            r_written  <= '0;
            r_error    <= 1'b0;
            r_state    <= (w_total == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (w_push) r_accepted <= r_accepted + AddrWidth'(1);
          if (w_pop)  r_written  <= r_written + AddrWidth'(1);
          if (w_drop) r_error    <= 1'b1;
          if (w_last) r_state    <= S_DONE;
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Result FIFO storage and occupancy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < FifoDepth; i++) r_mem[i] <= '0;
    end else if (w_start) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= result_data_i;
        r_wptr        <= r_wptr + PW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (PW+1)'(1);
      else if (!w_push && w_pop) r_count <= r_count - (PW+1)'(1);
    end
  end

endmodule

// File: tb/tb_gemm_result_writer.sv
// Directed bench for gemm_result_writer: one task per scenario,
// write traffic captured on the falling edge.
module tb_gemm_result_writer;

  localparam int AW = 16;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] msz = '0;
  logic [AW-1:0] nsz = '0;
  logic [AW-1:0] base = '0;
  logic          valid = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic          gnt = 1'b0;
  logic          req, we, busy, done, err;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;

  int total_n = 0;
  int bad_n = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic [AW-1:0] wa[$];
  logic [DW-1:0] wd[$];
  int            wc[$];

  gemm_result_writer #(
    .AddrWidth(AW), .DataWidth(DW), .M(4), .N(4), .FifoDepth(4)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .M_size_i(msz), .N_size_i(nsz), .base_addr_i(base),
    .result_valid_i(valid), .result_data_i(rdata),
    .sram_req_o(req), .sram_gnt_i(gnt), .sram_we_o(we),
    .sram_addr_o(addr), .sram_wdata_o(wdata),
    .busy_o(busy), .done_o(done), .error_o(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (req && gnt) begin
      wa.push_back(addr);
      wd.push_back(wdata);
      wc.push_back(cyc);
    end
    if (done) done_cnt++;
  end

  function automatic logic [DW-1:0] dv(input int k);
    return {32'(k), 32'hC0DE0000 ^ 32'(k), 32'(k * 3), 32'hFEED0000 + 32'(k)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [AW-1:0] m, input logic [AW-1:0] n,
                          input logic [AW-1:0] b);
    msz = m; nsz = n; base = b; start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic send(input int k);
    valid = 1'b1; rdata = dv(k);
    tick;
    valid = 1'b0; rdata = '0;
  endtask

  task automatic clr_mon;
    wa.delete(); wd.delete(); wc.delete();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    total_n++;
    if ({req, we, addr, wdata, busy, done, err} !== '0) begin
      bad_n++;
      $display("FAIL reset_outs got req=%b busy=%b done=%b err=%b addr=%h want all 0",
               req, busy, done, err, addr);
    end
    rst = 1'b0;
    tick;
    total_n++;
    if (busy !== 1'b0 || req !== 1'b0) begin
      bad_n++;
      $display("FAIL reset_idle got busy=%b req=%b want 0 0", busy, req);
    end
  endtask

  task automatic test_basic;
    bit ok;
    clr_mon;
    gnt = 1'b1;
    do_start(16'd8, 16'd8, 16'h0100);
    for (int i = 0; i < 4; i++) begin
      send(i);
      if (i < 3) begin tick; tick; end
    end
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done) begin ok = 1'b1; break; end
      tick;
    end
    total_n++;
    if (!ok) begin bad_n++; $display("FAIL basic_done got=0 want=1 (timeout)"); end
    total_n++;
    if (wa.size() !== 4) begin
      bad_n++; $display("FAIL basic_nwr got=%0d want=4", wa.size());
    end
    for (int i = 0; i < 4; i++) begin
      total_n++;
      if (wa[i] !== 16'h0100 + 16'(i) || wd[i] !== dv(i)) begin
        bad_n++;
        $display("FAIL basic_wr%0d got=%h want=%h", i, wa[i], 16'h0100 + 16'(i));
      end
    end
    total_n++;
    if (wc[3] + 1 !== cyc) begin
      bad_n++; $display("FAIL basic_done_lat got=%0d want=%0d", cyc - wc[3], 1);
    end
    total_n++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      bad_n++; $display("FAIL basic_done_st got busy=%b err=%b want 1 0", busy, err);
    end
    tick;
    total_n++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad_n++; $display("FAIL basic_after got done=%b busy=%b want 0 0", done, busy);
    end
    send(9);
    tick;
    total_n++;
    if (err !== 1'b0 || req !== 1'b0 || wa.size() !== 4) begin
      bad_n++;
      $display("FAIL basic_idle_valid got err=%b req=%b n=%0d want 0 0 4",
               err, req, wa.size());
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    clr_mon;
    gnt = 1'b0;
    do_start(16'd8, 16'd8, 16'h0100);
    for (int i = 0; i < 4; i++) send(10 + i);
    total_n++;
    if (err !== 1'b0 || req !== 1'b1 || we !== 1'b1) begin
      bad_n++; $display("FAIL bp_req got err=%b req=%b we=%b want 0 1 1", err, req, we);
    end
    total_n++;
    if (addr !== 16'h0100 || wdata !== dv(10)) begin
      bad_n++; $display("FAIL bp_head got=%h want=%h", addr, 16'h0100);
    end
    for (int k = 0; k < 6; k++) begin
      tick;
      total_n++;
      if (req !== 1'b1 || addr !== 16'h0100) begin
        bad_n++; $display("FAIL bp_stable%0d got req=%b addr=%h want 1 0100", k, req, addr);
      end
    end
    total_n++;
    if (wa.size() !== 0) begin
      bad_n++; $display("FAIL bp_nogrant got=%0d want=0", wa.size());
    end
    gnt = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done) begin ok = 1'b1; break; end
      tick;
    end
    total_n++;
    if (!ok) begin bad_n++; $display("FAIL bp_done got=0 want=1 (timeout)"); end
    total_n++;
    if (wa.size() !== 4) begin
      bad_n++; $display("FAIL bp_nwr got=%0d want=4", wa.size());
    end
    for (int i = 0; i < 4; i++) begin
      total_n++;
      if (wa[i] !== 16'h0100 + 16'(i) || wd[i] !== dv(10 + i) || wc[i] !== wc[0] + i) begin
        bad_n++;
        $display("FAIL bp_wr%0d got=%h want=%h", i, wa[i], 16'h0100 + 16'(i));
      end
    end
    tick;
  endtask

  task automatic test_overflow;
    bit ok;
    clr_mon;
    gnt = 1'b0;
    do_start(16'd16, 16'd16, 16'h0200);
    for (int i = 0; i < 5; i++) send(20 + i);
    total_n++;
    if (err !== 1'b1) begin
      bad_n++; $display("FAIL ovf_err got=%b want=1", err);
    end
    gnt = 1'b1;
    repeat (8) tick;
    total_n++;
    if (wa.size() !== 4 || err !== 1'b1) begin
      bad_n++; $display("FAIL ovf_nwr got=%0d err=%b want=4 1", wa.size(), err);
    end
    for (int i = 0; i < 4; i++) begin
      total_n++;
      if (wa[i] !== 16'h0200 + 16'(i) || wd[i] !== dv(20 + i)) begin
        bad_n++;
        $display("FAIL ovf_wr%0d got=%h want=%h", i, wa[i], 16'h0200 + 16'(i));
      end
    end
    for (int i = 0; i < 12; i++) send(30 + i);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done) begin ok = 1'b1; break; end
      tick;
    end
    total_n++;
    if (!ok || wa.size() !== 16) begin
      bad_n++; $display("FAIL ovf_finish got done=%b n=%0d want 1 16", ok, wa.size());
    end
    total_n++;
    if (wa[15] !== 16'h020F || wd[4] !== dv(30)) begin
      bad_n++; $display("FAIL ovf_tail got=%h want=020f", wa[15]);
    end
    tick;
    total_n++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      bad_n++; $display("FAIL ovf_sticky got err=%b busy=%b want 1 0", err, busy);
    end
  endtask

  task automatic test_full_pop;
    clr_mon;
    gnt = 1'b0;
    do_start(16'd16, 16'd16, 16'h0300);
    total_n++;
    if (err !== 1'b0) begin
      bad_n++; $display("FAIL fp_errclr got=%b want=0", err);
    end
    for (int i = 0; i < 4; i++) send(40 + i);
    gnt = 1'b1;
    send(44);
    gnt = 1'b0;
    total_n++;
    if (err !== 1'b0 || wa.size() !== 1) begin
      bad_n++; $display("FAIL fp_push got err=%b n=%0d want 0 1", err, wa.size());
    end
    total_n++;
    if (req !== 1'b1 || addr !== 16'h0301 || wdata !== dv(41)) begin
      bad_n++; $display("FAIL fp_head got req=%b addr=%h want 1 0301", req, addr);
    end
    gnt = 1'b1;
    repeat (6) tick;
    gnt = 1'b0;
    total_n++;
    if (wa.size() !== 5) begin
      bad_n++; $display("FAIL fp_occ got=%0d want=5", wa.size());
    end
    for (int i = 0; i < 5; i++) begin
      total_n++;
      if (wa[i] !== 16'h0300 + 16'(i) || wd[i] !== dv(40 + i)) begin
        bad_n++;
        $display("FAIL fp_wr%0d got=%h want=%h", i, wa[i], 16'h0300 + 16'(i));
      end
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_sizes;
    int dc0;
    bit ok;
    clr_mon;
    gnt = 1'b1;
    dc0 = done_cnt;
    do_start(16'd2, 16'd8, 16'h0000);
    total_n++;
    if (done !== 1'b1 || busy !== 1'b1 || req !== 1'b0) begin
      bad_n++;
      $display("FAIL zero_done got done=%b busy=%b req=%b want 1 1 0", done, busy, req);
    end
    tick;
    total_n++;
    if (done !== 1'b0 || busy !== 1'b0 || done_cnt !== dc0 + 1 || wa.size() !== 0) begin
      bad_n++;
      $display("FAIL zero_idle got done=%b pulses=%0d n=%0d want 0 1 0",
               done, done_cnt - dc0, wa.size());
    end
    do_start(16'd8, 16'd4, 16'h0400);
    for (int i = 0; i < 3; i++) send(50 + i);
    total_n++;
    if (err !== 1'b1) begin
      bad_n++; $display("FAIL excess_err got=%b want=1", err);
    end
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (done) begin ok = 1'b1; break; end
      tick;
    end
    total_n++;
    if (!ok || wa.size() !== 2) begin
      bad_n++; $display("FAIL excess_nwr got done=%b n=%0d want 1 2", ok, wa.size());
    end
    total_n++;
    if (wa[0] !== 16'h0400 || wa[1] !== 16'h0401 || wd[1] !== dv(51)) begin
      bad_n++; $display("FAIL excess_wr got=%h %h want=0400 0401", wa[0], wa[1]);
    end
    tick;
  endtask

  task automatic test_reset_mid;
    bit ok;
    clr_mon;
    gnt = 1'b0;
    do_start(16'd16, 16'd16, 16'h0500);
    send(60);
    send(61);
    total_n++;
    if (req !== 1'b1 || busy !== 1'b1) begin
      bad_n++; $display("FAIL rm_pre got req=%b busy=%b want 1 1", req, busy);
    end
    #2;
    rst = 1'b1;
    #1;
    total_n++;
    if ({req, we, addr, wdata, busy, done, err} !== '0) begin
      bad_n++;
      $display("FAIL rm_async got req=%b busy=%b addr=%h want all 0", req, busy, addr);
    end
    tick;
    rst = 1'b0;
    tick;
    do_start(16'd8, 16'd8, 16'h0600);
    total_n++;
    if (req !== 1'b0 || busy !== 1'b1) begin
      bad_n++; $display("FAIL rm_empty got req=%b busy=%b want 0 1", req, busy);
    end
    gnt = 1'b1;
    for (int i = 0; i < 4; i++) send(70 + i);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (done) begin ok = 1'b1; break; end
      tick;
    end
    total_n++;
    if (!ok || wa.size() !== 4) begin
      bad_n++; $display("FAIL rm_restart got done=%b n=%0d want 1 4", ok, wa.size());
    end
    total_n++;
    if (wa[0] !== 16'h0600 || wd[0] !== dv(70) || wa[3] !== 16'h0603) begin
      bad_n++; $display("FAIL rm_base got=%h want=0600", wa[0]);
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_overflow;
    test_full_pop;
    test_sizes;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
